// File: rtl/writeback.sv
// Writeback stage: selects ALU or load data, drives the register-file write port,
// waits for load data with a timeout and latches HALT. WB_RETIRE_CNT_EN adds retired_count.
module writeback #(
    parameter int DATA_W       = 32,
    parameter int REG_AW       = 3,
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [15:0]       inst_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [REG_AW-1:0] write_reg_in,
    input  logic              write_en_in,
    input  logic              mem_read_in,
    input  logic              halt_in,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdata_valid,
    output logic [REG_AW-1:0] write_reg_out,
    output logic              write_en_out,
    output logic [DATA_W-1:0] write_data,
    output logic              stall_out,
    output logic              halt_out,
    output logic              load_err
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]       retired_count
`endif
);

    localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

    localparam logic [1:0] ACCEPT    = 2'd0;
    localparam logic [1:0] WAIT_LOAD = 2'd1;
    localparam logic [1:0] HALTED    = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [REG_AW-1:0] lat_reg;
    logic              lat_en;

    // Instruction word is carried for trace only.
    logic unused_inst;
    assign unused_inst = ^inst_in;

    assign stall_out = (state != ACCEPT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ACCEPT;
            cnt           <= '0;
            lat_reg       <= '0;
            lat_en        <= 1'b0;
            write_reg_out <= '0;
            write_en_out  <= 1'b0;
            write_data    <= '0;
            halt_out      <= 1'b0;
            load_err      <= 1'b0;
        end else begin
            write_en_out <= 1'b0;
            load_err     <= 1'b0;
            case (state)
                ACCEPT: begin
                    if (valid_in) begin
                        if (halt_in) begin
                            halt_out <= 1'b1;
                            state    <= HALTED;
                        end else if (!mem_read_in) begin
                            write_en_out  <= write_en_in;
                            write_reg_out <= write_reg_in;
                            write_data    <= alu_result;
                        end else if (mem_rdata_valid) begin
                            write_en_out  <= write_en_in;
                            write_reg_out <= write_reg_in;
                            write_data    <= mem_rdata;
                        end else begin
                            lat_reg <= write_reg_in;
                            lat_en  <= write_en_in;
                            cnt     <= '0;
                            state   <= WAIT_LOAD;
                        end
                    end
                end
                WAIT_LOAD: begin
                    // Data in the final cycle still commits.
                    if (mem_rdata_valid) begin
                        write_en_out  <= lat_en;
                        write_reg_out <= lat_reg;
                        write_data    <= mem_rdata;
                        state         <= ACCEPT;
                    end else if (cnt == CNT_LAST) begin
                        load_err <= 1'b1;
                        state    <= ACCEPT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HALTED: begin
                    halt_out <= 1'b1;
                end
                default: state <= ACCEPT;
            endcase
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic retire;

    always_comb begin
        retire = 1'b0;
        case (state)
            ACCEPT:
                retire = valid_in &&
                         (halt_in || !mem_read_in || mem_rdata_valid);
            WAIT_LOAD:
                retire = mem_rdata_valid || (cnt == CNT_LAST);
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            retired_count <= '0;
        else if (retire)
            retired_count <= retired_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_writeback.sv
// Randomized and directed bench for writeback against a per-instruction outcome model.
// Define WB_RETIRE_CNT_EN to also check retired_count.
module tb_writeback;

    localparam int LT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [15:0] inst_in;
    logic [31:0] alu_result;
    logic [2:0]  write_reg_in;
    logic        write_en_in;
    logic        mem_read_in;
    logic        halt_in;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;
    logic [2:0]  write_reg_out;
    logic        write_en_out;
    logic [31:0] write_data;
    logic        stall_out;
    logic        halt_out;
    logic        load_err;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retired_count;
`endif

    always #5 clk = ~clk;

    writeback #(.DATA_W(32), .REG_AW(3), .LOAD_TIMEOUT(LT)) dut (
        .clk(clk),
        .rst(rst),
        .valid_in(valid_in),
        .inst_in(inst_in),
        .alu_result(alu_result),
        .write_reg_in(write_reg_in),
        .write_en_in(write_en_in),
        .mem_read_in(mem_read_in),
        .halt_in(halt_in),
        .mem_rdata(mem_rdata),
        .mem_rdata_valid(mem_rdata_valid),
        .write_reg_out(write_reg_out),
        .write_en_out(write_en_out),
        .write_data(write_data),
        .stall_out(stall_out),
        .halt_out(halt_out),
        .load_err(load_err)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retired_count(retired_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Expected outcome of the most recent clock edge
    logic        exp_we, exp_err, exp_stall, exp_halt;
    logic [2:0]  exp_reg;
    logic [31:0] exp_data;
    int unsigned exp_ret;

    task automatic cmp(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check(input string tag);
        cmp({tag, " write_en"}, 32'(write_en_out), 32'(exp_we));
        cmp({tag, " load_err"}, 32'(load_err), 32'(exp_err));
        cmp({tag, " stall"}, 32'(stall_out), 32'(exp_stall));
        cmp({tag, " halt"}, 32'(halt_out), 32'(exp_halt));
        if (exp_we) begin
            cmp({tag, " reg"}, 32'(write_reg_out), 32'(exp_reg));
            cmp({tag, " data"}, write_data, exp_data);
        end
`ifdef WB_RETIRE_CNT_EN
        cmp({tag, " retired"}, retired_count, exp_ret);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0;
        halt_in = 1'b0;
        mem_read_in = 1'b0;
        write_en_in = 1'b0;
        write_reg_in = 3'($urandom);
        alu_result = $urandom;
        mem_rdata = $urandom;
        mem_rdata_valid = 1'($urandom);
        inst_in = 16'($urandom);
    endtask

    // Non-load (or bubble when v=0); stray mem_rdata_valid must be ignored
    task automatic alu_op(input logic v, input logic en,
                          input logic [2:0] r, input logic [31:0] d);
        idle_inputs();
        valid_in = v;
        write_en_in = en;
        write_reg_in = r;
        alu_result = d;
        tick();
        exp_we = v & en;
        exp_reg = r;
        exp_data = d;
        exp_err = 1'b0;
        exp_stall = 1'b0;
        if (v) exp_ret++;
        check(v ? "alu" : "bubble");
    endtask

    // Load whose data arrives k cycles after acceptance (k=0: same cycle)
    task automatic load_op(input logic en, input logic [2:0] r,
                           input logic [31:0] d, input int k);
        int nwait;
        idle_inputs();
        valid_in = 1'b1;
        mem_read_in = 1'b1;
        write_en_in = en;
        write_reg_in = r;
        mem_rdata_valid = (k == 0);
        mem_rdata = (k == 0) ? d : $urandom;
        tick();
        nwait = (k <= LT) ? k : LT;
        for (int j = 1; j <= nwait; j++) begin
            exp_we = 1'b0;
            exp_err = 1'b0;
            exp_stall = 1'b1;
            check("load wait");
            write_reg_in = 3'($urandom);
            write_en_in = 1'($urandom);
            alu_result = $urandom;
            halt_in = 1'($urandom);
            mem_read_in = 1'($urandom);
            mem_rdata_valid = (j == k);
            mem_rdata = (j == k) ? d : $urandom;
            tick();
        end
        exp_stall = 1'b0;
        exp_ret++;
        if (k <= LT) begin
            exp_we = en;
            exp_reg = r;
            exp_data = d;
            exp_err = 1'b0;
        end else begin
            exp_we = 1'b0;
            exp_err = 1'b1;
        end
        check(k <= LT ? "load commit" : "load timeout");
    endtask

    initial begin
        exp_we = 1'b0;
        exp_err = 1'b0;
        exp_stall = 1'b0;
        exp_halt = 1'b0;
        exp_reg = '0;
        exp_data = '0;
        exp_ret = 0;
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b1;
        check("reset");
        cmp("reset reg", 32'(write_reg_out), 32'd0);
        cmp("reset data", write_data, 32'd0);

        // Reset while waiting for a load
        idle_inputs();
        valid_in = 1'b1;
        mem_read_in = 1'b1;
        write_en_in = 1'b1;
        write_reg_in = 3'd4;
        mem_rdata_valid = 1'b0;
        tick();
        cmp("pre-reset stall", 32'(stall_out), 32'd1);
        mem_rdata_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        idle_inputs();
        tick();
        exp_ret = 0;
        check("reset mid-wait");
        cmp("reset mid-wait reg", 32'(write_reg_out), 32'd0);
        cmp("reset mid-wait data", write_data, 32'd0);

        // Back-to-back non-loads
        alu_op(1'b1, 1'b1, 3'd1, 32'h11);
        alu_op(1'b1, 1'b1, 3'd2, 32'h22);
        alu_op(1'b1, 1'b1, 3'd3, 32'h33);

        load_op(1'b1, 3'd5, 32'hDEADBEEF, 4);
        alu_op(1'b1, 1'b1, 3'd6, 32'h66);
        load_op(1'b1, 3'd7, 32'hCAFE0001, LT + 5);
        load_op(1'b1, 3'd2, 32'h0BAD0BAD, LT);
        load_op(1'b1, 3'd1, 32'h12345678, 0);
        load_op(1'b1, 3'd3, 32'h87654321, 1);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0)
                load_op(1'($urandom), 3'($urandom), $urandom,
                        int'($urandom_range(0, LT + 3)));
            else
                alu_op(1'($urandom_range(0, 3) != 0), 1'($urandom),
                       3'($urandom), $urandom);
        end

        // HALT with write_en_in set: no write, terminal
        idle_inputs();
        valid_in = 1'b1;
        halt_in = 1'b1;
        write_en_in = 1'b1;
        write_reg_in = 3'd6;
        alu_result = 32'hFFFF0000;
        tick();
        exp_we = 1'b0;
        exp_err = 1'b0;
        exp_halt = 1'b1;
        exp_stall = 1'b1;
        exp_ret++;
        check("halt");
        for (int n = 0; n < 6; n++) begin
            idle_inputs();
            valid_in = 1'b1;
            write_en_in = 1'b1;
            mem_read_in = 1'($urandom);
            tick();
            check("halted");
        end

        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_halt = 1'b0;
        exp_stall = 1'b0;
        exp_ret = 0;
        check("reset after halt");
        alu_op(1'b1, 1'b1, 3'd0, 32'hA5A5A5A5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
